aes_encrypt_seq: RTL

Iterative, parametrised AES encryption core. It is the sequential successor to the team's combinational `AES_Encrypt`. It computes one AES round per clock, so area stays at one round datapath plus one on-the-fly key-expansion stage. It supports AES-128 and AES-256 via a parameter and uses valid/ready handshakes on input and output. It sits between the block-input staging logic and the ciphertext sink, and is the building block for later ECB/CTR wrappers.

---
 rtl/aes_encrypt_seq.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/aes_encrypt_seq.sv
// aes_encrypt_seq: iterative AES-128/AES-256 encryption core.
// One full round is computed per clock. The key schedule is expanded on the fly
// next to the round datapath, so no round keys are ever stored.
module aes_encrypt_seq #(
    parameter int KEY_LEN = 128
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [127:0]       plaintext,
    input  logic [KEY_LEN-1:0] key,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [127:0]       ciphertext,
    output logic               busy
);

    localparam int NR = (KEY_LEN == 256) ? 14 : 10;
    localparam logic [3:0] LAST_RND = NR[3:0];

    // Forward S-box, entry 0 first (leftmost), so SBOX[b] is S(b).
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fsm_t;

    fsm_t               fsm_q;
    fsm_t               fsm_d;
    logic [127:0]       blk_q;
    logic [KEY_LEN-1:0] key_q;
    logic [3:0]         rnd_q;
    logic [7:0]         rcon_q;

    logic               accept;
    logic [127:0]       shifted;
    logic [127:0]       mixed;
    logic [127:0]       round_out;
    logic [127:0]       round_key;
    logic [KEY_LEN-1:0] key_next;
    logic               rcon_step;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    // Multiply by x in GF(2^8); also used to step Rcon.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) begin
            r[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
        end
        return r;
    endfunction

    // Byte n of the block is row n%4, column n/4; row r rotates left by r columns.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        for (int c = 0; c < 4; c++) begin
            for (int rw = 0; rw < 4; rw++) begin
                r[127-8*(4*c+rw) -: 8] = s[127-8*(4*((c+rw)%4)+rw) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        for (int c = 0; c < 4; c++) begin
            r[127-32*c -: 32] = mix_column(s[127-32*c -: 32]);
        end
        return r;
    endfunction

    assign accept = in_valid && (fsm_q == ST_IDLE);

    // One AES round on the block register; the final round skips MixColumns.
    always_comb begin
        shifted   = shift_rows(sub_bytes(blk_q));
        mixed     = mix_columns(shifted);
        round_out = ((rnd_q == LAST_RND) ? shifted : mixed) ^ round_key;
    end

    generate
        if (KEY_LEN == 256) begin : g_key256
            // The key register is a sliding 8-word window {older 4 words, newer 4 words}.
            // Round 1 uses the newer half as loaded; every later round derives the next
            // 4 words with the single 4-S-box key path and shifts the window by 4 words.
            // Even rounds use RotWord+SubWord+Rcon, odd rounds SubWord only.
            logic [31:0] sw_in, t, n0, n1, n2, n3;

            // Derive the next 4 schedule words and pick this round's key.
            always_comb begin
                sw_in = rnd_q[0] ? key_q[31:0] : rot_word(key_q[31:0]);
                t     = sub_word(sw_in) ^ (rnd_q[0] ? 32'h0 : {rcon_q, 24'h0});
                n0    = key_q[255:224] ^ t;
                n1    = key_q[223:192] ^ n0;
                n2    = key_q[191:160] ^ n1;
                n3    = key_q[159:128] ^ n2;
                if (rnd_q == 4'd1) begin
                    round_key = key_q[127:0];
                    key_next  = key_q;
                end else begin
                    round_key = {n0, n1, n2, n3};
                    key_next  = {key_q[127:0], n0, n1, n2, n3};
                end
                rcon_step = ~rnd_q[0];
            end
        end else if (KEY_LEN == 128) begin : g_key128
            logic [31:0] t, n0, n1, n2, n3;

            // Each round key is the previous one advanced with RotWord+SubWord+Rcon.
            always_comb begin
                t         = sub_word(rot_word(key_q[31:0])) ^ {rcon_q, 24'h0};
                n0        = key_q[127:96] ^ t;
                n1        = key_q[95:64]  ^ n0;
                n2        = key_q[63:32]  ^ n1;
                n3        = key_q[31:0]   ^ n2;
                round_key = {n0, n1, n2, n3};
                key_next  = {n0, n1, n2, n3};
                rcon_step = 1'b1;
            end
        end else begin : g_bad_key_len
            $error("aes_encrypt_seq: KEY_LEN must be 128 or 256");
        end
    endgenerate

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q <= ST_IDLE;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    // Next-state logic: accept in IDLE, run Nr rounds, hold result until taken.
    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            ST_IDLE: if (in_valid)            fsm_d = ST_RUN;
            ST_RUN:  if (rnd_q == LAST_RND)   fsm_d = ST_DONE;
            ST_DONE: if (out_ready)           fsm_d = ST_IDLE;
            default:                          fsm_d = ST_IDLE;
        endcase
    end

    // Handshake and status outputs decode only the registered FSM state.
    always_comb begin
        in_ready  = (fsm_q == ST_IDLE);
        busy      = (fsm_q == ST_RUN);
        out_valid = (fsm_q == ST_DONE);
    end

    // Block, key window, round counter and Rcon: load on accept, step once per round.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_q  <= '0;
            key_q  <= '0;
            rnd_q  <= '0;
            rcon_q <= '0;
        end else if (accept) begin
            blk_q  <= plaintext ^ key[KEY_LEN-1 -: 128];
            key_q  <= key;
            rnd_q  <= 4'd1;
            rcon_q <= 8'h01;
        end else if (fsm_q == ST_RUN) begin
            blk_q  <= round_out;
            key_q  <= key_next;
            rnd_q  <= rnd_q + 4'd1;
            if (rcon_step) begin
                rcon_q <= xtime(rcon_q);
            end
        end
    end

    assign ciphertext = blk_q;

endmodule
